// File: rtl/mf_sequencer.sv
// mf_sequencer: control FSM for the 60-tap matched-filter correlator (load coefs, fill window, correlate, detect, holdoff).
// Latency: dp_x/dp_shift registered 1 cycle after a sample handshake; detected pulses LAT+1 cycles after the handshake.
// Backpressure: valid/ready on coef and samp; coef_valid or samp_valid low simply stalls, no timeout; cfg_abort drops readies.
// Ports: clk/rst (sync, active high); cfg_start/cfg_abort/cfg_threshold session control; coef_* load handshake and
//        datapath coefficient write; samp_* sample handshake; dp_x/dp_shift/dp_y datapath interface;
//        busy/detected/peak/peak_idx/state_o status (IDLE=0 LOAD=1 FILL=2 RUN=3 HOLD=4).
// Build option: define MF_SEQ_ABS_EN to evaluate |dp_y| (saturating) for peak and threshold compares.
module mf_sequencer #(
    parameter int ORDER   = 60,
    parameter int LAT     = 3,
    parameter int HOLDOFF = 16,
    parameter int IDXW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_abort,
    input  logic [37:0]     cfg_threshold,
    input  logic [15:0]     coef_in,
    input  logic            coef_valid,
    output logic            coef_ready,
    output logic            coef_we,
    output logic [5:0]      coef_addr,
    output logic [15:0]     coef_wdata,
    input  logic [15:0]     samp_in,
    input  logic            samp_valid,
    output logic            samp_ready,
    output logic [15:0]     dp_x,
    output logic            dp_shift,
    input  logic [37:0]     dp_y,
    output logic            busy,
    output logic            detected,
    output logic [37:0]     peak,
    output logic [IDXW-1:0] peak_idx,
    output logic [2:0]      state_o
);

    localparam int          HW       = $clog2(HOLDOFF + 1);
    localparam logic [5:0]  LAST_TAP = 6'(ORDER - 1);
    localparam logic [37:0] Y_MIN    = {1'b1, {37{1'b0}}};
`ifdef MF_SEQ_ABS_EN
    localparam logic [37:0] Y_MAX     = {1'b0, {37{1'b1}}};
    localparam logic [37:0] PEAK_INIT = '0;
`else
    localparam logic [37:0] PEAK_INIT = Y_MIN;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_RUN  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [37:0]     thr;
    logic [5:0]      coef_cnt;
    logic [5:0]      fill_cnt;
    logic [IDXW-1:0] samp_idx;
    logic [IDXW-1:0] shift_idx;
    logic            shift_full;
    logic [HW-1:0]   hold_cnt;
    logic            pipe_vld [LAT];
    logic [IDXW-1:0] pipe_idx [LAT];
    logic            ev_vld;
    logic [IDXW-1:0] ev_idx;
    logic [37:0]     ev_val;
    logic            ev_hit;
    logic            ev_peak;
    logic            coef_hs;
    logic            samp_hs;

    // Abort drops ready so a coincident handshake never happens.
    assign coef_ready = (state == S_LOAD) & ~cfg_abort;
    assign samp_ready = ((state == S_FILL) | (state == S_RUN) | (state == S_HOLD)) & ~cfg_abort;
    assign coef_hs    = coef_valid & coef_ready;
    assign samp_hs    = samp_valid & samp_ready;

    assign coef_we    = coef_hs;
    assign coef_addr  = coef_hs ? coef_cnt : '0;
    assign coef_wdata = coef_hs ? coef_in  : '0;
    assign busy       = (state != S_IDLE);
    assign state_o    = state;

    // Pipe tail lines up with the dp_y result of the shift LAT cycles earlier.
    assign ev_vld = pipe_vld[LAT-1];
    assign ev_idx = pipe_idx[LAT-1];

    always_comb begin
        ev_val = dp_y;
`ifdef MF_SEQ_ABS_EN
        if (dp_y == Y_MIN) begin
            ev_val = Y_MAX;
        end else if (dp_y[37]) begin
            ev_val = ~dp_y + 38'd1;
        end
`endif
    end

    assign ev_hit  = ev_vld & ($signed(ev_val) >= $signed(thr));
    assign ev_peak = ev_vld & ($signed(ev_val) >  $signed(peak));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_start) state_nxt = S_LOAD;
            S_LOAD: if (coef_hs && coef_cnt == LAST_TAP) state_nxt = S_FILL;
            S_FILL: if (samp_hs && fill_cnt == LAST_TAP) state_nxt = S_RUN;
            S_RUN:  if (ev_hit) state_nxt = S_HOLD;
            // A threshold hit evaluated on the exit cycle is still in HOLD and is ignored.
            S_HOLD: if (samp_hs && hold_cnt == HW'(1)) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr        <= '0;
            coef_cnt   <= '0;
            fill_cnt   <= '0;
            samp_idx   <= '0;
            shift_idx  <= '0;
            shift_full <= 1'b0;
            hold_cnt   <= '0;
            dp_x       <= '0;
            dp_shift   <= 1'b0;
            detected   <= 1'b0;
            peak       <= '0;
            peak_idx   <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else if (cfg_abort) begin
            // Session discarded; peak/peak_idx and dp_x keep their last values.
            coef_cnt   <= '0;
            fill_cnt   <= '0;
            samp_idx   <= '0;
            shift_full <= 1'b0;
            hold_cnt   <= '0;
            dp_shift   <= 1'b0;
            detected   <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            detected    <= (state == S_RUN) & ev_hit;
            pipe_vld[0] <= dp_shift & shift_full;
            pipe_idx[0] <= shift_idx;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (ev_peak) begin
                peak     <= ev_val;
                peak_idx <= ev_idx;
            end

            if (state == S_IDLE && cfg_start) begin
                thr      <= cfg_threshold;
                coef_cnt <= '0;
                fill_cnt <= '0;
                samp_idx <= '0;
                peak     <= PEAK_INIT;
                peak_idx <= '0;
            end

            if (coef_hs) coef_cnt <= coef_cnt + 6'd1;

            dp_shift <= samp_hs;
            if (samp_hs) begin
                dp_x       <= samp_in;
                shift_idx  <= samp_idx;
                // Only the ORDER-th and later samples produce a full-window result.
                shift_full <= (state != S_FILL) | (fill_cnt == LAST_TAP);
                samp_idx   <= samp_idx + IDXW'(1);
                if (state == S_FILL && fill_cnt != LAST_TAP) fill_cnt <= fill_cnt + 6'd1;
            end

            if (state == S_RUN && ev_hit) begin
                hold_cnt <= HW'(HOLDOFF);
            end else if (state == S_HOLD && samp_hs) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mf_sequencer.sv
// tb_mf_sequencer: randomized + directed bench for mf_sequencer against a transaction-level model.
// Latency: model schedules each accepted sample's evaluation LAT+1 edges after its handshake.
// Backpressure: bench drives valid randomly and expects ready from the model each cycle.
module tb_mf_sequencer;

    localparam int ORDER   = 60;
    localparam int LAT     = 3;
    localparam int HOLDOFF = 16;
    localparam int M_IDLE = 0, M_LOAD = 1, M_FILL = 2, M_RUN = 3, M_HOLD = 4;
    localparam logic signed [37:0] THR  = 38'sh0F00000000;
    localparam logic signed [37:0] MINV = {1'b1, {37{1'b0}}};
    localparam logic signed [37:0] MAXV = {1'b0, {37{1'b1}}};
`ifdef MF_SEQ_ABS_EN
    localparam logic signed [37:0] PINIT = '0;
`else
    localparam logic signed [37:0] PINIT = MINV;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0, cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [37:0] cfg_threshold = '0;
    logic [15:0] coef_in = '0, samp_in = '0;
    logic        coef_valid = 1'b0, samp_valid = 1'b0;
    logic [37:0] dp_y = '0;
    logic        coef_ready, coef_we, samp_ready, dp_shift, busy, detected;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata, dp_x, peak_idx;
    logic [37:0] peak;
    logic [2:0]  state_o;

    mf_sequencer #(.ORDER(ORDER), .LAT(LAT), .HOLDOFF(HOLDOFF), .IDXW(16)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_threshold(cfg_threshold), .coef_in(coef_in), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .samp_in(samp_in), .samp_valid(samp_valid),
        .samp_ready(samp_ready), .dp_x(dp_x), .dp_shift(dp_shift), .dp_y(dp_y),
        .busy(busy), .detected(detected), .peak(peak), .peak_idx(peak_idx),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic [15:0]        idx;
        bit                 full;
        logic signed [37:0] y;
    } ev_t;

    ev_t                evq[$];
    int                 checks = 0, failures = 0;
    int                 n = 0;
    int                 m_state = M_IDLE, m_coef = 0, m_nsamp = 0, m_hold = 0;
    logic [15:0]        m_idx = '0, m_pidx = '0, m_x = '0;
    logic signed [37:0] m_peak = '0, m_thr = '0, cur_thr = THR;
    bit                 m_det = 0, m_shift = 0;
    int                 det_seen = 0, det_edge = -1, hs60 = -1, we_cnt = 0, dup = 0;
    logic [63:0]        addr_seen = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic signed [37:0] mag(input logic signed [37:0] y);
`ifdef MF_SEQ_ABS_EN
        if (y == MINV) return MAXV;
        if (y < 0) return -y;
`endif
        return y;
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model at posedge, check state at next negedge.
    task automatic step(input bit r, input bit s, input bit a, input bit cv, input bit sv,
                        input logic signed [37:0] yv);
        ev_t                e;
        logic signed [37:0] v;
        int                 st;
        bit                 exp_cr, exp_sr;
        rst = r; cfg_start = s; cfg_abort = a; coef_valid = cv; samp_valid = sv;
        coef_in = 16'($urandom); samp_in = 16'($urandom); cfg_threshold = cur_thr;
        if (evq.size() > 0 && evq[0].due == n + 1) dp_y = evq[0].y;
        else dp_y = {6'($urandom), 32'($urandom)};
        #1;
        if (!r) begin
            exp_cr = (m_state == M_LOAD) && !a;
            exp_sr = (m_state >= M_FILL) && !a;
            check("coef_ready", coef_ready, exp_cr);
            check("samp_ready", samp_ready, exp_sr);
            check("coef_we", coef_we, exp_cr && cv);
            if (exp_cr && cv) begin
                check("coef_addr", coef_addr, m_coef);
                check("coef_wdata", coef_wdata, coef_in);
            end
        end
        if (coef_we) begin
            we_cnt++;
            if (addr_seen[coef_addr]) dup++;
            addr_seen[coef_addr] = 1'b1;
        end
        @(posedge clk);
        n++;
        if (r) begin
            m_state = M_IDLE; m_coef = 0; m_nsamp = 0; m_hold = 0; m_idx = '0;
            m_pidx = '0; m_x = '0; m_peak = '0; m_thr = '0; m_det = 0; m_shift = 0;
            evq.delete();
        end else if (a) begin
            m_state = M_IDLE; m_coef = 0; m_nsamp = 0; m_hold = 0; m_idx = '0;
            m_det = 0; m_shift = 0;
            evq.delete();
        end else begin
            st = m_state;
            m_det = 0;
            if (evq.size() > 0 && evq[0].due == n) begin
                e = evq.pop_front();
                if (e.full) begin
                    v = mag(e.y);
                    if (v > m_peak) begin m_peak = v; m_pidx = e.idx; end
                    if (st == M_RUN && v >= m_thr) begin
                        m_det = 1; m_state = M_HOLD; m_hold = HOLDOFF;
                    end
                end
            end
            m_shift = 0;
            case (st)
                M_IDLE: if (s) begin
                    m_state = M_LOAD; m_thr = cur_thr; m_coef = 0; m_nsamp = 0;
                    m_idx = '0; m_peak = PINIT; m_pidx = '0;
                end
                M_LOAD: if (cv) begin
                    m_coef++;
                    if (m_coef == ORDER) m_state = M_FILL;
                end
                default: if (sv) begin
                    e.due = n + LAT + 1; e.idx = m_idx; e.full = (m_nsamp + 1 >= ORDER); e.y = yv;
                    evq.push_back(e);
                    m_shift = 1; m_x = samp_in; m_idx++; m_nsamp++;
                    if (st == M_FILL && m_nsamp == ORDER) m_state = M_RUN;
                    if (st == M_HOLD) begin
                        m_hold--;
                        if (m_hold == 0) m_state = M_RUN;
                    end
                end
            endcase
        end
        @(negedge clk);
        check("state", state_o, m_state);
        check("busy", busy, m_state != M_IDLE);
        check("detected", detected, m_det);
        check("peak", peak, $unsigned(m_peak));
        check("peak_idx", peak_idx, m_pidx);
        check("dp_shift", dp_shift, m_shift);
        check("dp_x", dp_x, m_x);
        if (detected) begin
            det_seen++;
            if (det_edge < 0) det_edge = n;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 0, 0, '0);
    endtask

    task automatic load_all();
        for (int i = 0; i < 400 && m_coef < ORDER; i++) step(0, 0, 0, 1, 0, '0);
    endtask

    initial begin
        logic signed [37:0] y, nthr;
        @(negedge clk);
        repeat (3) step(1, 0, 0, 0, 0, '0);
        check("rst_state", state_o, 0);
        check("rst_peak", peak, 0);
        check("rst_pidx", peak_idx, 0);

        // Coefficient load with coef_valid low every third cycle.
        cur_thr = THR;
        step(0, 1, 0, 0, 0, '0);
        check("load_state", state_o, M_LOAD);
        we_cnt = 0; dup = 0; addr_seen = '0;
        for (int i = 0; i < 400 && m_coef < ORDER; i++) step(0, 0, 0, (i % 3) != 2, 0, '0);
        check("fill_state", state_o, M_FILL);
        check("coef_we_count", we_cnt, ORDER);
        check("coef_addr_cover", addr_seen[59:0], {60{1'b1}});
        check("coef_addr_dup", dup, 0);

        // 59 samples at threshold never evaluate.
        det_seen = 0;
        for (int i = 0; i < 800 && m_nsamp < ORDER - 1; i++)
            step(0, 0, 0, 0, $urandom_range(0, 3) != 0, THR);
        idle(LAT + 2);
        check("fill_no_det", det_seen, 0);
        check("fill_peak", peak, $unsigned(PINIT));

        // 60th sample equal to threshold detects LAT+1 cycles after its handshake.
        det_edge = -1;
        step(0, 0, 0, 0, 1, THR);
        hs60 = n;
        idle(LAT + 3);
        check("det_latency", det_edge - hs60, LAT + 1);
        check("det_pidx", peak_idx, ORDER - 1);
        check("det_peak", peak, $unsigned(THR));
        check("hold_state", state_o, M_HOLD);

        // Holdoff: 16 accepted samples, then RUN.
        for (int i = 0; i < HOLDOFF; i++) step(0, 0, 0, 0, 1, THR + 1);
        check("hold_exit_run", state_o, M_RUN);
        idle(LAT + 3);
        check("hold_peak", peak, $unsigned(THR + 38'sd1));
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, $urandom_range(0, 1), THR + 2);
        idle(LAT + 3);

        // Randomized traffic with occasional start, abort and reset.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 2))
                0: cur_thr = THR;
                1: cur_thr = 38'sd1000;
                default: cur_thr = -38'sd1000;
            endcase
            case ($urandom_range(0, 5))
                0: y = m_thr;
                1: y = m_thr - 1;
                2: y = m_thr + 1;
                3: y = -m_thr;
                4: y = MINV;
                default: y = {6'($urandom), 32'($urandom)};
            endcase
            step($urandom_range(0, 1499) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, y);
        end

        // Abort in RUN coincident with samp_valid.
        step(0, 0, 1, 0, 0, '0);
        cur_thr = THR;
        step(0, 1, 0, 0, 0, '0);
        load_all();
        for (int i = 0; i < 400 && m_nsamp < ORDER; i++) step(0, 0, 0, 0, 1, 38'sd5);
        idle(LAT + 3);
        check("run_state", state_o, M_RUN);
        step(0, 0, 1, 0, 1, THR);
        check("abort_idle", state_o, M_IDLE);
        check("abort_shift", dp_shift, 0);
        check("abort_peak", peak, 5);
        check("abort_pidx", peak_idx, ORDER - 1);

        // Negative correlation of threshold magnitude.
        step(0, 1, 0, 0, 0, '0);
        load_all();
        for (int i = 0; i < 400 && m_nsamp < ORDER - 1; i++) step(0, 0, 0, 0, 1, '0);
        det_seen = 0;
        nthr = -THR;
        step(0, 0, 0, 0, 1, nthr);
        idle(LAT + 3);
`ifdef MF_SEQ_ABS_EN
        check("neg_det", det_seen, 1);
        check("neg_peak", peak, $unsigned(THR));
`else
        check("neg_det", det_seen, 0);
        check("neg_peak", peak, $unsigned(nthr));
`endif

        // Reset in the middle of LOAD.
        step(0, 0, 1, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        repeat (10) step(0, 0, 0, 1, 0, '0);
        step(1, 0, 0, 1, 1, '0);
        check("rstmid_state", state_o, 0);
        check("rstmid_peak", peak, 0);
        check("rstmid_pidx", peak_idx, 0);
        check("rstmid_dpx", dp_x, 0);
        check("rstmid_busy", busy, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
